// File: rtl/cache_refill_responder.sv
// cache_refill_responder: backing word array answering block-fill reads with a BEATS-word burst and writes with a one-cycle ack after LATENCY cycles
module cache_refill_responder #(
  parameter int MEM_WORDS = 16384,
  parameter int BEATS = 2,
  parameter int LATENCY = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_beat,
  output logic        rsp_last,
  output logic        wr_ack
);
  localparam int aw = $clog2(MEM_WORDS);
  localparam int cw = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [aw-1:0] blk_mask = aw'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;
  state_t state;
  logic [31:0] mem [MEM_WORDS];
  logic [aw-1:0] idx, base;
  logic [cw-1:0] cnt;
  logic is_write, accept, unused_addr;
  assign idx = req_addr[aw+1:2];
  assign unused_addr = ^{req_addr[31:aw+2], req_addr[1:0]};
  assign accept = state == IDLE && req_valid && req_ready;
  always_ff @(posedge CLK)
    if (accept && req_write) mem[idx] <= req_wdata;
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state <= IDLE;
      is_write <= 1'b0;
      base <= '0;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_beat <= '0;
      rsp_last <= 1'b0;
      wr_ack <= 1'b0;
    end else
      case (state)
        IDLE:
          if (accept) begin
            is_write <= req_write;
            base <= req_write ? idx : idx & ~blk_mask;
            cnt <= cw'(LATENCY - 1);
            req_ready <= 1'b0;
            state <= WAIT;
          end else req_ready <= 1'b1;
        WAIT:
          if (cnt != '0) cnt <= cnt - cw'(1);
          else if (is_write) begin
            wr_ack <= 1'b1;
            state <= WACK;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data <= mem[base];
            rsp_beat <= '0;
            rsp_last <= BEATS == 1;
            state <= BURST;
          end
        BURST:
          if (rsp_ready && rsp_last) begin
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_beat <= '0;
            rsp_last <= 1'b0;
            req_ready <= 1'b1;
            state <= IDLE;
          end else if (rsp_ready) begin
            rsp_beat <= rsp_beat + 3'd1;
            rsp_data <= mem[base + aw'(rsp_beat + 3'd1)];
            rsp_last <= rsp_beat == 3'(BEATS - 2);
          end
        default: begin
          wr_ack <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_cache_refill_responder.sv
// tb_cache_refill_responder: scoreboard bench with a word-array reference model for the refill responder
module tb_cache_refill_responder;
  localparam int MW = 16384;
  localparam int NB = 2;
  localparam int LAT = 4;
  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic rsp_ready = 1'b1;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_last, wr_ack;
  logic [31:0] rsp_data;
  logic [2:0] rsp_beat;
  cache_refill_responder #(.MEM_WORDS(MW), .BEATS(NB), .LATENCY(LAT), .INIT_FILE("")) dut (
    .CLK(CLK), .RESETn(RESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_beat(rsp_beat), .rsp_last(rsp_last), .wr_ack(wr_ack)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int total = 0, bad = 0;
  int accepts = 0, completes = 0, aborts = 0;
  int rel_cyc = 1 << 30;
  bit rnd = 1'b0;
  int stall_total = 0, stall_used = 0;
  logic [31:0] model [MW];
  typedef struct {bit ack; logic [31:0] data; int beat; bit last; int t;} exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input bit keep);
    int n, ix, b;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    ix = int'((a >> 2) % MW);
    accepts++;
    if (w) begin
      model[ix] = d;
      q.push_back('{1'b1, 32'd0, 0, 1'b0, cyc + 1 + LAT});
    end else begin
      b = ix - ix % NB;
      for (int i = 0; i < NB; i++)
        q.push_back('{1'b0, model[b + i], i, i == NB - 1, i == 0 ? cyc + 1 + LAT : -1});
    end
    @(posedge CLK);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() > 0 || accepts != completes + aborts) && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  initial forever begin
    @(posedge CLK);
    #2;
    if (stall_used < stall_total && rsp_valid && rsp_beat == 3'd1) begin
      rsp_ready = 1'b0;
      stall_used++;
    end else rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  end
  initial forever begin
    @(negedge CLK);
    if (!RESETn) begin
      chk("reset_ctl", {25'd0, rsp_valid, wr_ack, req_ready, rsp_last, rsp_beat}, 32'd0);
      chk("reset_data", rsp_data, 32'd0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(cyc > rel_cyc && accepts == completes + aborts));
      chk("valid_ack_excl", 32'(rsp_valid & wr_ack), 32'd0);
      if (q.size() > 0 && q[0].t >= 0 && cyc > q[0].t) begin
        chk("resp_late", 32'(cyc), 32'(q[0].t));
        q[0].t = -1;
      end
      if (rsp_valid) begin
        chk("beat_expected", 32'(q.size() > 0 && !q[0].ack), 32'd1);
        if (q.size() > 0 && !q[0].ack) begin
          chk("rsp_data", rsp_data, q[0].data);
          chk("rsp_beat", 32'(rsp_beat), 32'(q[0].beat));
          chk("rsp_last", 32'(rsp_last), 32'(q[0].last));
          if (q[0].t >= 0) begin
            chk("first_beat_cyc", 32'(cyc), 32'(q[0].t));
            q[0].t = -1;
          end
          if (rsp_ready) begin
            if (q[0].last) completes++;
            void'(q.pop_front());
          end
        end
      end
      if (wr_ack) begin
        chk("ack_expected", 32'(q.size() > 0 && q[0].ack), 32'd1);
        if (q.size() > 0 && q[0].ack) begin
          if (q[0].t >= 0) chk("ack_cyc", 32'(cyc), 32'(q[0].t));
          void'(q.pop_front());
          completes++;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] a;
    #1;
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    RESETn = 1'b1;
    rel_cyc = cyc;
    rnd = 1'b1;
    for (int i = 0; i < 128; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b0);
    rnd = 1'b0;
    issue(1'b0, 32'h0000_0014, 32'd0, 1'b0);
    wait_idle();
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h0000_0100, 32'd0, 1'b0);
    wait_idle();
    stall_total = 3;
    issue(1'b0, 32'h0000_003C, 32'd0, 1'b0);
    wait_idle();
    chk("stall_cycles", 32'(stall_used), 32'(stall_total));
    for (int i = 0; i < 8; i++)
      issue(i[0], i[0] ? 32'h0000_0104 : 32'h0000_0028, $urandom, i < 7);
    wait_idle();
    issue(1'b0, 32'h0001_0008, 32'd0, 1'b0);
    wait_idle();
    issue(1'b0, 32'h0000_0020, 32'd0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("burst_seen", 32'(rsp_valid), 32'd1);
    RESETn = 1'b0;
    aborts = accepts - completes;
    q.delete();
    #1;
    chk("async_drop", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge CLK);
    #1;
    RESETn = 1'b1;
    rel_cyc = cyc;
    issue(1'b0, 32'h0000_0020, 32'd0, 1'b0);
    wait_idle();
    rnd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_0003) | 32'($urandom_range(0, 127) << 2);
      issue($urandom_range(0, 2) == 0, a, $urandom, i < 59 && $urandom_range(0, 1) == 1);
    end
    wait_idle();
    req_valid = 1'b0;
    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
